l2_cache_responder: RTL and testbench

//  Direct-mapped, write-back, write-allocate L2 cache. Serves the L1 side of the L2_* request interface.

---
 rtl/l2_cache_responder_if.sv | 26 ++
 rtl/l2_cache_responder.sv | 205 ++++++++++++++++++++
 tb/tb_l2_cache_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_responder_if.sv
// L1-side request bus and main-memory line bus of the L2 cache responder.
// slave: the cache's view; master: the requester/memory-side view.
interface l2_cache_responder_if;
    logic         L2_read;
    logic         L2_write;
    logic [29:0]  L2_addr;
    logic [31:0]  L2_wdata;
    logic [127:0] L2_rdata;
    logic         L2_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  L2_read, L2_write, L2_addr, L2_wdata, mem_rdata, mem_ready,
        output L2_rdata, L2_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output L2_read, L2_write, L2_addr, L2_wdata, mem_rdata, mem_ready,
        input  L2_rdata, L2_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_cache_responder.sv
// Direct-mapped, write-back, write-allocate L2 cache with 128-bit lines.
// Word-addressed L1 requests always receive the whole line; misses evict a
// dirty victim and refill from memory.
// Optional macro L2_STATS_EN adds saturating hit/miss counters.
module l2_cache_responder #(
    parameter int INDEX_W = 5
) (
    input  logic                clk,
    input  logic                proc_reset_n,
    l2_cache_responder_if.slave bus
`ifdef L2_STATS_EN
    ,
    output logic [31:0]         stat_hit_cnt,
    output logic [31:0]         stat_miss_cnt
`endif
);
    localparam int TAG_W = 28 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESP} state_t;

    state_t             r_state;

    // Line storage; valid/dirty are the only bits that need a reset.
    logic [127:0]       r_data [LINES];
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;

    // Request captured on acceptance, used for the rest of the transaction.
    logic [TAG_W-1:0]   r_req_tag;
    logic [INDEX_W-1:0] r_req_idx;
    logic [1:0]         r_req_word;
    logic [31:0]        r_req_wdata;
    logic               r_req_wr;

    // Registered outputs.
    logic [127:0]       r_l2_rdata;
    logic               r_l2_ready;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [27:0]        r_mem_addr;
    logic [127:0]       r_mem_wdata;

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   word,
                                                input logic [31:0]  wdata);
        logic [127:0] v;
        v = line;
        case (word)
            2'd0:    v[31:0]   = wdata;
            2'd1:    v[63:32]  = wdata;
            2'd2:    v[95:64]  = wdata;
            default: v[127:96] = wdata;
        endcase
        return v;
    endfunction

    logic               w_req;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic               w_hit;
    logic               w_victim_dirty;
    logic [127:0]       w_hit_line;
    logic [127:0]       w_fill_line;
    logic               w_accept;
    logic               w_fill;
    logic               w_wr_en;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0]   w_wr_tag;
    logic [127:0]       w_wr_line;
    logic               w_wr_dirty;

    assign w_req          = bus.L2_read | bus.L2_write;
    assign w_idx          = bus.L2_addr[INDEX_W+1:2];
    assign w_tag          = bus.L2_addr[29:INDEX_W+2];
    assign w_word         = bus.L2_addr[1:0];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    // A write (even with read also high) returns the merged line.
    assign w_hit_line     = bus.L2_write ? merge_word(r_data[w_idx], w_word, bus.L2_wdata)
                                         : r_data[w_idx];
    assign w_fill_line    = r_req_wr ? merge_word(bus.mem_rdata, r_req_word, r_req_wdata)
                                     : bus.mem_rdata;
    assign w_accept       = (r_state == IDLE) && w_req;
    assign w_fill         = (r_state == ALLOCATE) && bus.mem_ready;

    // Two sources update a line: a write hit in IDLE and a refill in ALLOCATE.
    assign w_wr_en        = (w_accept && w_hit && bus.L2_write) || w_fill;
    assign w_wr_idx       = w_fill ? r_req_idx   : w_idx;
    assign w_wr_tag       = w_fill ? r_req_tag   : w_tag;
    assign w_wr_line      = w_fill ? w_fill_line : w_hit_line;
    assign w_wr_dirty     = w_fill ? r_req_wr    : 1'b1;

    // Line data and tag arrays: plain storage, no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[w_wr_idx] <= w_wr_line;
            r_tag[w_wr_idx]  <= w_wr_tag;
        end
    end

    // Valid/dirty bits: cleared by reset, set on every line update.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_dirty[w_wr_idx] <= w_wr_dirty;
        end
    end

    // Control FSM with registered L1 and memory-side outputs.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_state     <= IDLE;
            r_l2_ready  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_l2_rdata  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_l2_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_req_tag   <= w_tag;
                        r_req_idx   <= w_idx;
                        r_req_word  <= w_word;
                        r_req_wdata <= bus.L2_wdata;
                        r_req_wr    <= bus.L2_write;
                        if (w_hit) begin
                            r_l2_rdata <= w_hit_line;
                            r_l2_ready <= 1'b1;
                            r_state    <= RESP;
                        end else if (w_victim_dirty) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx};
                            r_mem_wdata <= r_data[w_idx];
                            r_state     <= WRITEBACK;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_tag, w_idx};
                            r_state    <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= {r_req_tag, r_req_idx};
                        r_state     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_mem_read <= 1'b0;
                        r_l2_rdata <= w_fill_line;
                        r_l2_ready <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.L2_rdata  = r_l2_rdata;
    assign bus.L2_ready  = r_l2_ready;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef L2_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating hit/miss counters, one event per accepted request.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign stat_hit_cnt  = r_hit_cnt;
    assign stat_miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_l2_cache_responder.sv
// Scoreboard bench for l2_cache_responder: directed requests push expected
// lines/latencies and expected memory operations into queues; monitors pop
// and compare when the DUT presents L2_ready or starts a memory transaction.
module tb_l2_cache_responder;
    localparam int MEM_LAT = 3;

    typedef struct {
        logic [127:0] line;
        int           lat;
        int           issue;
    } resp_t;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } memop_t;

    logic clk = 1'b0;
    logic proc_reset_n;
    int   cnt = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    logic prev_mr = 1'b0;
    logic prev_mw = 1'b0;
    logic prev_rdy = 1'b0;
    logic [127:0] mem_line = '0;

    resp_t  exp_q[$];
    memop_t mem_q[$];

    l2_cache_responder_if bus();

`ifdef L2_STATS_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    l2_cache_responder dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus)
`ifdef L2_STATS_EN
        ,
        .stat_hit_cnt (stat_hit_cnt),
        .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    // Memory model: answers each read/write with a one-cycle mem_ready after MEM_LAT cycles.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
                repeat (MEM_LAT) @(posedge clk);
                #1;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_line;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = '0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every L2_ready.
    always @(negedge clk) begin
        resp_t r;
        if (mon_en) begin
            check("ready_not_back_to_back", {127'b0, prev_rdy & bus.L2_ready}, 128'd0);
            check("mem_rw_exclusive", {127'b0, bus.mem_read & bus.mem_write}, 128'd0);
            if (bus.L2_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_l2_ready", 128'd1, 128'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("l2_rdata", bus.L2_rdata, r.line);
                    check("l2_latency", {96'b0, cnt - r.issue}, {96'b0, r.lat});
                end
            end
            prev_rdy = bus.L2_ready;
        end
    end

    // Memory-side monitor: checks each new mem_read/mem_write against the queue.
    always @(negedge clk) begin
        memop_t m;
        if (mon_en) begin
            if (bus.mem_read && !prev_mr) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_read", 128'd1, 128'd0);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_op_kind_read", {127'b0, m.wr}, 128'd0);
                    check("mem_read_addr", {100'b0, bus.mem_addr}, {100'b0, m.addr});
                end
            end
            if (bus.mem_write && !prev_mw) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_write", 128'd1, 128'd0);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_op_kind_write", {127'b0, m.wr}, 128'd1);
                    check("mem_write_addr", {100'b0, bus.mem_addr}, {100'b0, m.addr});
                    check("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
            prev_mr = bus.mem_read;
            prev_mw = bus.mem_write;
        end
    end

    task automatic push_mem(input logic wr, input logic [27:0] addr, input logic [127:0] wd);
        memop_t m;
        m.wr = wr;
        m.addr = addr;
        m.wdata = wd;
        mem_q.push_back(m);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wd, input logic [127:0] exp_line, input int lat);
        resp_t e;
        int n;
        @(posedge clk);
        #1;
        e.line  = exp_line;
        e.lat   = lat;
        e.issue = cnt;
        exp_q.push_back(e);
        bus.L2_read  = rd;
        bus.L2_write = wr;
        bus.L2_addr  = addr;
        bus.L2_wdata = wd;
        n = 0;
        while (bus.L2_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("l2_ready_seen", {127'b0, bus.L2_ready}, 128'd1);
        bus.L2_read  = 1'b0;
        bus.L2_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] l1, l3, l4, l5m, l7, l6;
        int n;
        l1  = 128'h4444_3333_2222_1111;
        l3  = {32'h0, 32'hDEADBEEF, 64'h4444_3333_2222_1111};
        l4  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        l5m = {32'h5555_5555, 32'h5555_5555, 32'hCAFE_F00D, 32'h5555_5555};
        l7  = {32'h1234_5678, 32'h5555_5555, 32'hCAFE_F00D, 32'h5555_5555};
        l6  = 128'h6666_0000_6666_1111_6666_2222_6666_3333;

        proc_reset_n = 1'b0;
        bus.L2_read  = 1'b0;
        bus.L2_write = 1'b0;
        bus.L2_addr  = '0;
        bus.L2_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_l2_ready",  {127'b0, bus.L2_ready}, 128'd0);
        check("rst_mem_read",  {127'b0, bus.mem_read}, 128'd0);
        check("rst_mem_write", {127'b0, bus.mem_write}, 128'd0);
        check("rst_l2_rdata",  bus.L2_rdata, 128'd0);
        check("rst_mem_addr",  {100'b0, bus.mem_addr}, 128'd0);
        check("rst_mem_wdata", bus.mem_wdata, 128'd0);
`ifdef L2_STATS_EN
        check("rst_stat_hit",  {96'b0, stat_hit_cnt}, 128'd0);
        check("rst_stat_miss", {96'b0, stat_miss_cnt}, 128'd0);
`endif
        proc_reset_n = 1'b1;
        mon_en = 1'b1;

        // T1 cold read miss
        mem_line = l1;
        push_mem(1'b0, 28'h4, '0);
        do_req(1'b1, 1'b0, 30'h10, 32'h0, l1, MEM_LAT + 2);
        // T2 read hit
        do_req(1'b1, 1'b0, 30'h11, 32'h0, l1, 1);
        // T3 write hit, word 2
        do_req(1'b0, 1'b1, 30'h12, 32'hDEAD_BEEF, l3, 1);
        // T4 dirty conflict read at index 4, tag 1
        mem_line = l4;
        push_mem(1'b1, 28'h4, l3);
        push_mem(1'b0, 28'h24, '0);
        do_req(1'b1, 1'b0, 30'h90, 32'h0, l4, 2 * MEM_LAT + 3);
`ifdef L2_STATS_EN
        @(posedge clk);
        #1;
        check("stat_hit_t1_t4",  {96'b0, stat_hit_cnt}, 128'd2);
        check("stat_miss_t1_t4", {96'b0, stat_miss_cnt}, 128'd2);
`endif
        // Refilled line now hits
        do_req(1'b1, 1'b0, 30'h93, 32'h0, l4, 1);
        // Write miss into clean/invalid index 9: refill then merge word 1
        mem_line = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        push_mem(1'b0, 28'h9, '0);
        do_req(1'b0, 1'b1, 30'h25, 32'hCAFE_F00D, l5m, MEM_LAT + 2);
        do_req(1'b1, 1'b0, 30'h24, 32'h0, l5m, 1);
        // Read and write together: treated as a write of word 3
        do_req(1'b1, 1'b1, 30'h27, 32'h1234_5678, l7, 1);

        // T5 reset during WRITEBACK of dirty index 9
        push_mem(1'b1, 28'h9, l7);
        @(posedge clk);
        #1;
        bus.L2_read = 1'b1;
        bus.L2_addr = 30'hA4;
        n = 0;
        while (bus.mem_write !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_writeback_started", {127'b0, bus.mem_write}, 128'd1);
        @(posedge clk);
        #1;
        proc_reset_n = 1'b0;
        bus.L2_read  = 1'b0;
        @(posedge clk);
        #1;
        check("t5_mem_write_dropped", {127'b0, bus.mem_write}, 128'd0);
        check("t5_mem_read_low",      {127'b0, bus.mem_read}, 128'd0);
        check("t5_l2_ready_low",      {127'b0, bus.L2_ready}, 128'd0);
        proc_reset_n = 1'b1;
        repeat (10) @(posedge clk);
        // Line 4 was valid before reset; it must miss now with no writeback.
        mem_line = l6;
        push_mem(1'b0, 28'h4, '0);
        do_req(1'b1, 1'b0, 30'h10, 32'h0, l6, MEM_LAT + 2);
`ifdef L2_STATS_EN
        @(posedge clk);
        #1;
        check("stat_hit_after_rst",  {96'b0, stat_hit_cnt}, 128'd0);
        check("stat_miss_after_rst", {96'b0, stat_miss_cnt}, 128'd1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("resp_queue_drained", {96'b0, 32'(exp_q.size())}, 128'd0);
        check("mem_queue_drained",  {96'b0, 32'(mem_q.size())}, 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
